// File: rtl/cmatmul_pkg.sv
// -----------------------------------------------------------------------------
// cmatmul_pkg
// Shared definitions for the sequential complex matrix multiplier:
//   - default values for the element width (W) and matrix dimension (N)
//   - FSM state encoding used by cmatmul_seq
//   - ow_width(): signed result width needed so an N-term complex dot
//     product of W-bit signed operands can never overflow
// -----------------------------------------------------------------------------
package cmatmul_pkg;

  localparam int CMM_W_DEFAULT = 4;
  localparam int CMM_N_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // One W x W signed product needs 2W bits, the sum of two products one more,
  // and accumulating N of those sums another clog2(N).
  function automatic int ow_width(input int w, input int n);
    return 2 * w + 1 + $clog2(n);
  endfunction

endpackage

// File: rtl/cmatmul_cmac.sv
// -----------------------------------------------------------------------------
// cmac
// Complex multiply-accumulate datapath with its own accumulator registers.
// Each enabled cycle adds (ar + j*ai) * (br +/- j*bi) to the accumulator,
// using the conjugate of b when conj=1. All arithmetic is carried out at the
// full OW-bit signed width, so intermediate products and sums never wrap.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (clears accumulator)
//   clr            clear accumulator (has priority over en)
//   en             accumulate this cycle
//   conj           1: use conj(b), 0: use b
//   ar, ai         W-bit signed real/imag of the A operand
//   br, bi         W-bit signed real/imag of the B operand
//   sum_r, sum_i   accumulator plus current product (value that en would store)
// -----------------------------------------------------------------------------
module cmac #(
  parameter int W  = 4,
  parameter int OW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic          conj,
  input  logic [W-1:0]  ar,
  input  logic [W-1:0]  ai,
  input  logic [W-1:0]  br,
  input  logic [W-1:0]  bi,
  output logic [OW-1:0] sum_r,
  output logic [OW-1:0] sum_i
);

  logic signed [OW-1:0] acc_r_reg;
  logic signed [OW-1:0] acc_i_reg;
  logic signed [OW-1:0] ar_x;
  logic signed [OW-1:0] ai_x;
  logic signed [OW-1:0] br_x;
  logic signed [OW-1:0] bi_x;
  logic signed [OW-1:0] bi_eff;
  logic signed [OW-1:0] prod_r;
  logic signed [OW-1:0] prod_i;
  logic signed [OW-1:0] sum_r_next;
  logic signed [OW-1:0] sum_i_next;

  // Sign-extend before any arithmetic; negating the most negative W-bit value
  // is only safe once the operand is wider than W.
  assign ar_x = {{(OW-W){ar[W-1]}}, ar};
  assign ai_x = {{(OW-W){ai[W-1]}}, ai};
  assign br_x = {{(OW-W){br[W-1]}}, br};
  assign bi_x = {{(OW-W){bi[W-1]}}, bi};

  assign bi_eff = conj ? -bi_x : bi_x;

  assign prod_r = (ar_x * br_x) - (ai_x * bi_eff);
  assign prod_i = (ar_x * bi_eff) + (ai_x * br_x);

  assign sum_r_next = acc_r_reg + prod_r;
  assign sum_i_next = acc_i_reg + prod_i;

  assign sum_r = sum_r_next;
  assign sum_i = sum_i_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r_reg <= '0;
      acc_i_reg <= '0;
    end else if (clr) begin
      acc_r_reg <= '0;
      acc_i_reg <= '0;
    end else if (en) begin
      acc_r_reg <= sum_r_next;
      acc_i_reg <= sum_i_next;
    end
  end

endmodule

// File: rtl/cmatmul_seq.sv
// -----------------------------------------------------------------------------
// cmatmul_seq
// Sequential N x N complex matrix multiplier C = A*B (or A*conj(B)), one
// complex MAC per cycle through a single cmac instance. Results are streamed
// out in row-major order through a valid/ready handshake.
//
// Matrices are flattened: element (r,c) occupies bits [(r*N+c)*W +: W].
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  request a product (only looked at in IDLE)
//   conj_b                 0: A*B, 1: A*conj(B); latched with the operands
//   A_real/A_imag          N*N*W-bit flattened signed operand A
//   B_real/B_imag          N*N*W-bit flattened signed operand B
//   busy                   high from the cycle after an accepted start
//                          through the done cycle
//   out_valid, out_ready   result handshake
//   out_row, out_col       index of the presented element
//   out_real, out_imag     OW-bit signed result element
//   done                   one-cycle pulse after the last element is taken
//
// Timing with out_ready high: first out_valid N+1 cycles after the start
// cycle, done N*N*(N+1)+1 cycles after it. Legal N is 2..16.
// -----------------------------------------------------------------------------
module cmatmul_seq
  import cmatmul_pkg::*;
#(
  parameter int W = CMM_W_DEFAULT,
  parameter int N = CMM_N_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     conj_b,
  input  logic [N*N*W-1:0]         A_real,
  input  logic [N*N*W-1:0]         A_imag,
  input  logic [N*N*W-1:0]         B_real,
  input  logic [N*N*W-1:0]         B_imag,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N)-1:0]     out_row,
  output logic [$clog2(N)-1:0]     out_col,
  output logic [ow_width(W,N)-1:0] out_real,
  output logic [ow_width(W,N)-1:0] out_imag,
  output logic                     done
);

  localparam int OW = ow_width(W, N);
  localparam int IW = $clog2(N);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MAC  = ST_MAC;
  localparam logic [1:0] S_OUT  = ST_OUT;
  localparam logic [1:0] S_FIN  = ST_FIN;

  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  logic [1:0]       state_reg;
  logic [IW-1:0]    i_reg;
  logic [IW-1:0]    j_reg;
  logic [IW-1:0]    k_reg;
  logic             conj_reg;
  logic [N*N*W-1:0] a_re_reg;
  logic [N*N*W-1:0] a_im_reg;
  logic [N*N*W-1:0] b_re_reg;
  logic [N*N*W-1:0] b_im_reg;
  logic [OW-1:0]    out_real_reg;
  logic [OW-1:0]    out_imag_reg;

  logic [W-1:0]     a_re_m [N][N];
  logic [W-1:0]     a_im_m [N][N];
  logic [W-1:0]     b_re_m [N][N];
  logic [W-1:0]     b_im_m [N][N];

  logic [W-1:0]     ar_sel;
  logic [W-1:0]     ai_sel;
  logic [W-1:0]     br_sel;
  logic [W-1:0]     bi_sel;
  logic [OW-1:0]    sum_r;
  logic [OW-1:0]    sum_i;

  logic             accept;
  logic             handshake;
  logic             k_last;
  logic             j_last;
  logic             i_last;
  logic             acc_clr;
  logic             acc_en;

  // ---------------------------------------------------------------------------
  // View the latched flat operand vectors as 2-D element arrays.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      assign a_re_m[gi][gj] = a_re_reg[(gi*N+gj)*W +: W];
      assign a_im_m[gi][gj] = a_im_reg[(gi*N+gj)*W +: W];
      assign b_re_m[gi][gj] = b_re_reg[(gi*N+gj)*W +: W];
      assign b_im_m[gi][gj] = b_im_reg[(gi*N+gj)*W +: W];
    end
  end

  // Current MAC term: A[i][k] * B[k][j]
  assign ar_sel = a_re_m[i_reg][k_reg];
  assign ai_sel = a_im_m[i_reg][k_reg];
  assign br_sel = b_re_m[k_reg][j_reg];
  assign bi_sel = b_im_m[k_reg][j_reg];

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign accept    = (state_reg == S_IDLE) && start;
  assign handshake = (state_reg == S_OUT) && out_ready;
  assign k_last    = (k_reg == IDX_LAST);
  assign j_last    = (j_reg == IDX_LAST);
  assign i_last    = (i_reg == IDX_LAST);

  // The accumulator is cleared whenever a new element begins: on the accepted
  // start and on every output handshake.
  assign acc_clr = accept || handshake;
  assign acc_en  = (state_reg == S_MAC);

  cmac #(
    .W  (W),
    .OW (OW)
  ) u_cmac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .conj  (conj_reg),
    .ar    (ar_sel),
    .ai    (ai_sel),
    .br    (br_sel),
    .bi    (bi_sel),
    .sum_r (sum_r),
    .sum_i (sum_i)
  );

  // ---------------------------------------------------------------------------
  // FSM, counters and operand/result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      i_reg        <= '0;
      j_reg        <= '0;
      k_reg        <= '0;
      conj_reg     <= 1'b0;
      a_re_reg     <= '0;
      a_im_reg     <= '0;
      b_re_reg     <= '0;
      b_im_reg     <= '0;
      out_real_reg <= '0;
      out_imag_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            a_re_reg  <= A_real;
            a_im_reg  <= A_imag;
            b_re_reg  <= B_real;
            b_im_reg  <= B_imag;
            conj_reg  <= conj_b;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            state_reg <= S_MAC;
          end
        end

        S_MAC: begin
          if (k_last) begin
            // Capture the final sum including this last term, so the
            // result is ready the cycle OUT is entered.
            k_reg        <= '0;
            out_real_reg <= sum_r;
            out_imag_reg <= sum_i;
            state_reg    <= S_OUT;
          end else begin
            k_reg <= k_reg + 1'b1;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            // Row-major walk: column first, row advances on column wrap.
            j_reg <= j_last ? '0 : j_reg + 1'b1;
            if (j_last) begin
              i_reg <= i_last ? '0 : i_reg + 1'b1;
            end
            state_reg <= (i_last && j_last) ? S_FIN : S_MAC;
          end
        end

        S_FIN: begin
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Row/column counters only move on a handshake, so they double as
  // the presented index and stay stable under backpressure.
  // ---------------------------------------------------------------------------
  assign busy      = (state_reg != S_IDLE);
  assign out_valid = (state_reg == S_OUT);
  assign done      = (state_reg == S_FIN);
  assign out_row   = i_reg;
  assign out_col   = j_reg;
  assign out_real  = out_real_reg;
  assign out_imag  = out_imag_reg;

endmodule

// File: tb/tb_cmatmul_seq.sv
// -----------------------------------------------------------------------------
// tb_cmatmul_seq
// Directed self-checking bench for cmatmul_seq with W=3, N=4 (OW=9).
// Expected results are hand constants for the structured cases and a plain
// triple-loop reference for the random cases.
// -----------------------------------------------------------------------------
module tb_cmatmul_seq;

  localparam int W  = 3;
  localparam int N  = 4;
  localparam int NE = N * N;
  localparam int OW = 9;
  localparam int IW = 2;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 conj_b;
  logic [NE*W-1:0]      A_real;
  logic [NE*W-1:0]      A_imag;
  logic [NE*W-1:0]      B_real;
  logic [NE*W-1:0]      B_imag;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        out_row;
  logic [IW-1:0]        out_col;
  logic signed [OW-1:0] out_real;
  logic signed [OW-1:0] out_imag;
  logic                 done;

  int n_checks = 0;
  int n_fail   = 0;

  int ar_t [NE];
  int ai_t [NE];
  int br_t [NE];
  int bi_t [NE];
  int er   [NE];
  int ei   [NE];

  cmatmul_seq #(
    .W (W),
    .N (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .conj_b    (conj_b),
    .A_real    (A_real),
    .A_imag    (A_imag),
    .B_real    (B_real),
    .B_imag    (B_imag),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_ops();
    for (int e = 0; e < NE; e++) begin
      A_real[e*W +: W] = W'(ar_t[e]);
      A_imag[e*W +: W] = W'(ai_t[e]);
      B_real[e*W +: W] = W'(br_t[e]);
      B_imag[e*W +: W] = W'(bi_t[e]);
    end
  endtask

  task automatic set_all(input int ar, input int ai, input int br, input int bi,
                         input int r, input int im);
    for (int e = 0; e < NE; e++) begin
      ar_t[e] = ar; ai_t[e] = ai; br_t[e] = br; bi_t[e] = bi;
      er[e]   = r;  ei[e]   = im;
    end
  endtask

  task automatic rand_ops();
    for (int e = 0; e < NE; e++) begin
      ar_t[e] = int'($urandom_range(7, 0)) - 4;
      ai_t[e] = int'($urandom_range(7, 0)) - 4;
      br_t[e] = int'($urandom_range(7, 0)) - 4;
      bi_t[e] = int'($urandom_range(7, 0)) - 4;
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k] * B'[k][j], B' = B or conj(B)
  task automatic model(input logic cj);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        int sr;
        int si;
        sr = 0;
        si = 0;
        for (int k = 0; k < N; k++) begin
          int xr, xi, yr, yi;
          xr = ar_t[i*N+k];
          xi = ai_t[i*N+k];
          yr = br_t[k*N+j];
          yi = cj ? -bi_t[k*N+j] : bi_t[k*N+j];
          sr += xr * yr - xi * yi;
          si += xr * yi + xi * yr;
        end
        er[i*N+j] = sr;
        ei[i*N+j] = si;
      end
    end
  endtask

  // Runs one full product and checks every presented element against er/ei.
  //   stall_e : element index held with out_ready=0 for 5 cycles (-1: none)
  //   abuse   : pulse start and scramble all inputs while busy
  //   abort_e : element index at which rst_n is pulled low (-1: none)
  task automatic run_product(input string tag, input logic cj, input int stall_e,
                             input bit abuse, input int abort_e);
    int cyc;
    int exp_cyc;
    logic signed [OW-1:0] h_re, h_im;
    logic [IW-1:0] h_row, h_col;
    @(negedge clk);
    drive_ops();
    conj_b    = cj;
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    chk({tag, " busy_after_start"}, busy, 1);
    for (int e = 0; e < NE; e++) begin
      int w;
      w = 0;
      if (abuse && e == 1) begin
        start  = 1'b1;
        conj_b = ~cj;
        A_real = ~A_real;
        A_imag = ~A_imag;
        B_real = ~B_real;
        B_imag = ~B_imag;
      end
      if (abuse && e == 3) start = 1'b0;
      while (!out_valid && w < 4 * N) begin
        @(posedge clk);
        #1;
        cyc++;
        w++;
      end
      chk($sformatf("%s valid e%0d", tag, e), out_valid, 1);
      if (!out_valid) return;
      if (e == 0) chk({tag, " first_latency"}, cyc, N + 1);
      chk($sformatf("%s row e%0d", tag, e), out_row, e / N);
      chk($sformatf("%s col e%0d", tag, e), out_col, e % N);
      chk($sformatf("%s real e%0d", tag, e), out_real, er[e]);
      chk($sformatf("%s imag e%0d", tag, e), out_imag, ei[e]);
      if (e == abort_e) begin
        rst_n = 1'b0;
        #1;
        chk({tag, " rst busy"}, busy, 0);
        chk({tag, " rst valid"}, out_valid, 0);
        chk({tag, " rst done"}, done, 0);
        chk({tag, " rst row"}, out_row, 0);
        chk({tag, " rst col"}, out_col, 0);
        chk({tag, " rst real"}, out_real, 0);
        chk({tag, " rst imag"}, out_imag, 0);
        return;
      end
      if (e == stall_e) begin
        out_ready = 1'b0;
        h_re  = out_real;
        h_im  = out_imag;
        h_row = out_row;
        h_col = out_col;
        repeat (5) begin
          @(posedge clk);
          #1;
          cyc++;
          chk({tag, " stall valid"}, out_valid, 1);
          chk({tag, " stall row"}, out_row, h_row);
          chk({tag, " stall col"}, out_col, h_col);
          chk({tag, " stall real"}, out_real, h_re);
          chk({tag, " stall imag"}, out_imag, h_im);
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (e < NE - 1) begin
        chk($sformatf("%s valid_drop e%0d", tag, e), out_valid, 0);
        chk($sformatf("%s no_done e%0d", tag, e), done, 0);
        chk($sformatf("%s busy e%0d", tag, e), busy, 1);
      end
    end
    exp_cyc = NE * (N + 1) + 1 + ((stall_e >= 0) ? 5 : 0);
    chk({tag, " done_pulse"}, done, 1);
    chk({tag, " done_cycles"}, cyc, exp_cyc);
    @(posedge clk);
    #1;
    chk({tag, " done_single"}, done, 0);
    chk({tag, " idle_busy"}, busy, 0);
    $display("run %s finished after %0d cycles", tag, cyc);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    conj_b    = 1'b0;
    out_ready = 1'b1;
    A_real    = '0;
    A_imag    = '0;
    B_real    = '0;
    B_imag    = '0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset valid", out_valid, 0);
    chk("reset done", done, 0);
    chk("reset row", out_row, 0);
    chk("reset col", out_col, 0);
    chk("reset real", out_real, 0);
    chk("reset imag", out_imag, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // Identity A, random B: C must equal B
    rand_ops();
    for (int e = 0; e < NE; e++) begin
      ar_t[e] = (e / N == e % N) ? 1 : 0;
      ai_t[e] = 0;
      er[e]   = br_t[e];
      ei[e]   = bi_t[e];
    end
    run_product("ident", 1'b0, -1, 1'b0, -1);

    // (-4-4i)^2 = 32i per term, x4 -> 0 + 128i
    set_all(-4, -4, -4, -4, 0, 128);
    run_product("imag_ext", 1'b0, -1, 1'b0, -1);

    // (-4-4i)(-4+3i) = 28 + 4i per term, x4 -> 112 + 16i
    set_all(-4, -4, -4, 3, 112, 16);
    run_product("real_ext", 1'b0, -1, 1'b0, -1);

    // (1+i)(1-i) = 2 per term -> 8 + 0i
    set_all(1, 1, 1, 1, 8, 0);
    run_product("conj1", 1'b1, -1, 1'b0, -1);

    // (1+i)(1+i) = 2i per term -> 0 + 8i, with start/input abuse while busy
    set_all(1, 1, 1, 1, 0, 8);
    run_product("conj0_abuse", 1'b0, -1, 1'b1, -1);

    // Random product with backpressure on element (1,2)
    rand_ops();
    model(1'b0);
    run_product("stall", 1'b0, 6, 1'b0, -1);

    // Reset while element (2,0) is presented
    set_all(-4, -4, -4, 3, 112, 16);
    run_product("abort", 1'b0, -1, 1'b0, 8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_abort busy", busy, 0);
    chk("post_abort valid", out_valid, 0);

    // Fresh random conjugate product after the abort
    rand_ops();
    model(1'b1);
    run_product("after_abort", 1'b1, -1, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
